axil_reg_responder: RTL

//  AXI4-Lite responder (slave) terminating the shell's s_axil register path. Holds NUM_REGS
//  32-bit RW control registers at REG_BASE + 4*i, drives them to the datapath as a flat vector,
//  and pulses a per-register strobe on every committed write. Answers both AW/W/B and AR/R.

---
 rtl/axil_reg_responder.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/axil_reg_responder.sv
// AXI4-Lite register responder: NUM_REGS RW 32-bit registers at REG_BASE + 4*i with per-register write strobes.
// Define AXIL_REG_WSTRB_EN to add the s_axil_wstrb port and byte-granular register writes.
module axil_reg_responder #(
    parameter int          ADDR_WIDTH = 32,
    parameter int          NUM_REGS   = 8,
    parameter logic [31:0] REG_BASE   = 32'h0000_1000,
    parameter logic [31:0] ERR_DATA   = 32'hDEADBEEF
) (
    input  logic                     axil_aclk,
    input  logic                     axil_rst,
    input  logic                     s_axil_awvalid,
    input  logic [ADDR_WIDTH-1:0]    s_axil_awaddr,
    output logic                     s_axil_awready,
    input  logic                     s_axil_wvalid,
    input  logic [31:0]              s_axil_wdata,
`ifdef AXIL_REG_WSTRB_EN
    input  logic [3:0]               s_axil_wstrb,
`endif
    output logic                     s_axil_wready,
    output logic                     s_axil_bvalid,
    output logic [1:0]               s_axil_bresp,
    input  logic                     s_axil_bready,
    input  logic                     s_axil_arvalid,
    input  logic [ADDR_WIDTH-1:0]    s_axil_araddr,
    output logic                     s_axil_arready,
    output logic                     s_axil_rvalid,
    output logic [31:0]              s_axil_rdata,
    output logic [1:0]               s_axil_rresp,
    input  logic                     s_axil_rready,
    output logic [NUM_REGS*32-1:0]   reg_out,
    output logic [NUM_REGS-1:0]      reg_wr_pulse
);

    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [ADDR_WIDTH-1:0] BASE  = ADDR_WIDTH'(REG_BASE);
    localparam logic [ADDR_WIDTH-1:0] LIMIT = ADDR_WIDTH'(NUM_REGS);

    localparam logic [1:0] W_IDLE    = 2'd0;
    localparam logic [1:0] W_HAVE_AW = 2'd1;
    localparam logic [1:0] W_HAVE_W  = 2'd2;
    localparam logic [1:0] W_RESP    = 2'd3;

    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_DATA = 1'b1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic [1:0]            w_state;
    logic [0:0]            r_state;
    logic [ADDR_WIDTH-1:0] aw_addr_q;
    logic [31:0]           w_data_q;
    logic [3:0]            w_strb_q;
    logic [31:0]           regs [NUM_REGS];

    logic                  aw_hs, w_hs, commit;
    logic [3:0]            wstrb_in;
    logic [ADDR_WIDTH-1:0] wr_addr, wr_off, rd_off;
    logic [31:0]           wr_data;
    logic [3:0]            wr_strb;
    logic                  wr_mapped, rd_mapped;
    logic [IDX_W-1:0]      wr_idx, rd_idx;

`ifdef AXIL_REG_WSTRB_EN
    assign wstrb_in = s_axil_wstrb;
`else
    assign wstrb_in = 4'hF;
`endif

    assign s_axil_awready = (w_state == W_IDLE) || (w_state == W_HAVE_W);
    assign s_axil_wready  = (w_state == W_IDLE) || (w_state == W_HAVE_AW);
    assign s_axil_arready = (r_state == R_IDLE);

    assign aw_hs = s_axil_awvalid && s_axil_awready;
    assign w_hs  = s_axil_wvalid && s_axil_wready;

    // Commit takes the address/data from whichever side arrives on this edge, else from the latch.
    always_comb begin
        commit  = 1'b0;
        wr_addr = s_axil_awaddr;
        wr_data = s_axil_wdata;
        wr_strb = wstrb_in;
        case (w_state)
            W_IDLE:    commit = aw_hs && w_hs;
            W_HAVE_AW: begin
                commit  = w_hs;
                wr_addr = aw_addr_q;
            end
            W_HAVE_W:  begin
                commit  = aw_hs;
                wr_data = w_data_q;
                wr_strb = w_strb_q;
            end
            default:   commit = 1'b0;
        endcase
    end

    always_comb begin
        wr_off    = wr_addr - BASE;
        wr_mapped = (wr_addr >= BASE) && ((wr_off >> 2) < LIMIT);
        wr_idx    = wr_off[IDX_W+1:2];
        rd_off    = s_axil_araddr - BASE;
        rd_mapped = (s_axil_araddr >= BASE) && ((rd_off >> 2) < LIMIT);
        rd_idx    = rd_off[IDX_W+1:2];
    end

    always_comb begin
        reg_out = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            reg_out[32*i +: 32] = regs[i];
        end
    end

    always_ff @(posedge axil_aclk or posedge axil_rst) begin
        if (axil_rst) begin
            w_state       <= W_IDLE;
            aw_addr_q     <= '0;
            w_data_q      <= '0;
            w_strb_q      <= '0;
            s_axil_bvalid <= 1'b0;
            s_axil_bresp  <= RESP_OKAY;
            reg_wr_pulse  <= '0;
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            reg_wr_pulse <= '0;
            if (commit) begin
                w_state       <= W_RESP;
                s_axil_bvalid <= 1'b1;
                if (wr_mapped) begin
                    s_axil_bresp         <= RESP_OKAY;
                    reg_wr_pulse[wr_idx] <= 1'b1;
                    for (int unsigned k = 0; k < 4; k++) begin
                        if (wr_strb[k]) begin
                            regs[wr_idx][8*k +: 8] <= wr_data[8*k +: 8];
                        end
                    end
                end else begin
                    s_axil_bresp <= RESP_SLVERR;
                end
            end else begin
                case (w_state)
                    W_IDLE: begin
                        if (aw_hs) begin
                            aw_addr_q <= s_axil_awaddr;
                            w_state   <= W_HAVE_AW;
                        end else if (w_hs) begin
                            w_data_q <= s_axil_wdata;
                            w_strb_q <= wstrb_in;
                            w_state  <= W_HAVE_W;
                        end
                    end
                    W_RESP: begin
                        if (s_axil_bready) begin
                            s_axil_bvalid <= 1'b0;
                            w_state       <= W_IDLE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // rdata samples regs before any same-edge write lands, so a racing read sees the old value.
    always_ff @(posedge axil_aclk or posedge axil_rst) begin
        if (axil_rst) begin
            r_state       <= R_IDLE;
            s_axil_rvalid <= 1'b0;
            s_axil_rdata  <= '0;
            s_axil_rresp  <= RESP_OKAY;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (s_axil_arvalid) begin
                        r_state       <= R_DATA;
                        s_axil_rvalid <= 1'b1;
                        if (rd_mapped) begin
                            s_axil_rdata <= regs[rd_idx];
                            s_axil_rresp <= RESP_OKAY;
                        end else begin
                            s_axil_rdata <= ERR_DATA;
                            s_axil_rresp <= RESP_SLVERR;
                        end
                    end
                end
                default: begin
                    if (s_axil_rready) begin
                        s_axil_rvalid <= 1'b0;
                        r_state       <= R_IDLE;
                    end
                end
            endcase
        end
    end

endmodule
